// File: rtl/mem_io_responder.sv
// CPU bus target: 256x8 RAM, buffered OUT FIFO, single-entry IN register.
// Define MEM_IO_LOADER_EN to add the external RAM loader port.
module mem_io_responder #(
  parameter int OUT_DEPTH = 4,
  parameter     INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_bus,
  input  logic       c_ri,
  input  logic       c_ro,
  input  logic       mem_clk,
  input  logic       mem_io,
  inout  wire  [7:0] bus,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_overflow,
  output logic       in_underflow
`ifdef MEM_IO_LOADER_EN
  ,
  input  logic       load_we,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       cpu_hold
`endif
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(OUT_DEPTH);

  logic [7:0]    mem [256];
  logic [7:0]    fifo [OUT_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    in_hold;
  logic          in_full;

  logic       rd;
  logic       wr;
  logic       commit;
  logic       drive;
  logic       full;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       io_rd;
  logic [7:0] rdata;

  assign rd     = c_ro & ~c_ri;
  assign wr     = c_ri & ~c_ro;
  assign commit = mem_clk & reset;
  assign drive  = rd & reset;

  assign rdata = mem_io ? (in_full ? in_hold : 8'h00)
                        : mem[addr_bus];
  assign bus   = drive ? rdata : 8'bz;

  assign full      = count == FULL_CNT;
  assign out_valid = count != '0;
  assign out_data  = fifo[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push_req  = commit & wr & mem_io;
  // a pop in the same clk frees the slot, so a full FIFO still accepts
  assign push      = push_req & (~full | pop);
  assign io_rd     = commit & rd & mem_io;
  assign in_ready  = ~in_full;

  // loader write is applied last so it wins an address collision
  always_ff @(posedge clk) begin
    if (commit && wr && !mem_io)
      mem[addr_bus] <= bus;
`ifdef MEM_IO_LOADER_EN
    if (load_we)
      mem[load_addr] <= load_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= bus;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (push_req && full && !pop)
        out_overflow <= 1'b1;
    end
  end

  // consume and capture are exclusive: capture needs the register empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_full      <= 1'b0;
      in_underflow <= 1'b0;
    end else begin
      if (io_rd && in_full) begin
        in_full <= 1'b0;
      end else if (in_valid && !in_full) begin
        in_full <= 1'b1;
        in_hold <= in_data;
      end
      if (io_rd && !in_full)
        in_underflow <= 1'b1;
    end
  end

`ifdef MEM_IO_LOADER_EN
  always_ff @(posedge clk) begin
    if (!reset)
      cpu_hold <= 1'b0;
    else
      cpu_hold <= load_we;
  end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
// Each scenario task drives stimulus and compares inline.
module tb_mem_io_responder;

  logic       clk = 0;
  logic       reset;
  logic [7:0] addr_bus;
  logic       c_ri;
  logic       c_ro;
  logic       mem_clk;
  logic       mem_io;
  wire  [7:0] bus;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_overflow;
  logic       in_underflow;
`ifdef MEM_IO_LOADER_EN
  logic       load_we = 0;
  logic [7:0] load_addr = 0;
  logic [7:0] load_data = 0;
  logic       cpu_hold;
`endif

  logic [7:0] tb_bus;
  logic       tb_drv;
  int checks = 0;
  int failures = 0;

  assign bus = tb_drv ? tb_bus : 8'bz;

  always #5 clk = ~clk;

  mem_io_responder #(.OUT_DEPTH(4), .INIT_FILE("")) dut (
    .clk(clk),
    .reset(reset),
    .addr_bus(addr_bus),
    .c_ri(c_ri),
    .c_ro(c_ro),
    .mem_clk(mem_clk),
    .mem_io(mem_io),
    .bus(bus),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_overflow(out_overflow),
    .in_underflow(in_underflow)
`ifdef MEM_IO_LOADER_EN
    ,
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .cpu_hold(cpu_hold)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0;
    tick();
    tick();
    reset = 1;
    #1;
  endtask

  task automatic bus_write(input logic io, input logic [7:0] a,
                           input logic [7:0] d);
    mem_io = io;
    addr_bus = a;
    c_ri = 1;
    tb_bus = d;
    tb_drv = 1;
    mem_clk = 1;
    tick();
    mem_clk = 0;
    c_ri = 0;
    tb_drv = 0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow got=%b want=0", out_overflow);
    end
    checks++;
    if (in_underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_underflow got=%b want=0", in_underflow);
    end
  endtask

  task automatic test_ram;
    bus_write(0, 8'h3C, 8'hA5);
    bus_write(0, 8'h3D, 8'h5C);
    mem_io = 0;
    addr_bus = 8'h3C;
    #1;
    checks++;
    if (!(bus === 8'hzz || bus === 8'h00)) begin
      failures++;
      $display("FAIL ram_idle_release got=%h want=zz", bus);
    end
    c_ro = 1;
    #1;
    checks++;
    if (bus !== 8'hA5) begin
      failures++;
      $display("FAIL ram_read_3c got=%h want=a5", bus);
    end
    addr_bus = 8'h3D;
    #1;
    checks++;
    if (bus !== 8'h5C) begin
      failures++;
      $display("FAIL ram_read_3d got=%h want=5c", bus);
    end
    c_ro = 0;
    #1;
  endtask

  task automatic test_out_fifo;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 5; i++)
      bus_write(1, 8'h00, 8'(i + 1));
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_valid got=%b want=1", out_valid);
    end
    checks++;
    if (out_overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_overflow got=%b want=1", out_overflow);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_data !== 8'(i + 1)) begin
        failures++;
        $display("FAIL fill_drain%0d got=%h want=%h", i, out_data, 8'(i + 1));
      end
      tick();
    end
    out_ready = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_empty got=%b want=0", out_valid);
    end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h12, 8'h13, 8'h77};
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++)
      bus_write(1, 8'h00, 8'(8'h10 + i));
    out_ready = 1;
    bus_write(1, 8'h00, 8'h77);
    out_ready = 0;
    #1;
    checks++;
    if (out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL pp_overflow got=%b want=0", out_overflow);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_data !== exp[i]) begin
        failures++;
        $display("FAIL pp_drain%0d got=%h want=%h", i, out_data, exp[i]);
      end
      tick();
    end
    out_ready = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_empty got=%b want=0", out_valid);
    end
  endtask

  task automatic test_in_path;
    do_reset();
    in_valid = 1;
    in_data = 8'h5A;
    tick();
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL in_ready_fall got=%b want=0", in_ready);
    end
    mem_io = 1;
    c_ro = 1;
    #1;
    checks++;
    if (bus !== 8'h5A) begin
      failures++;
      $display("FAIL in_read got=%h want=5a", bus);
    end
    mem_clk = 1;
    tick();
    mem_clk = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_consume got=%b want=1", in_ready);
    end
    checks++;
    if (bus !== 8'h00) begin
      failures++;
      $display("FAIL in_empty_read got=%h want=00", bus);
    end
    checks++;
    if (in_underflow !== 1'b0) begin
      failures++;
      $display("FAIL in_no_underflow got=%b want=0", in_underflow);
    end
    mem_clk = 1;
    tick();
    mem_clk = 0;
    c_ro = 0;
    checks++;
    if (in_underflow !== 1'b1) begin
      failures++;
      $display("FAIL in_underflow got=%b want=1", in_underflow);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    in_valid = 1;
    in_data = 8'h11;
    tick();
    in_data = 8'h22;
    mem_io = 1;
    c_ro = 1;
    mem_clk = 1;
    tick();
    mem_clk = 0;
    c_ro = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_blocked got=%b want=1", in_ready);
    end
    tick();
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_capture got=%b want=0", in_ready);
    end
    c_ro = 1;
    #1;
    checks++;
    if (bus !== 8'h22) begin
      failures++;
      $display("FAIL b2b_data got=%h want=22", bus);
    end
    c_ro = 0;
    #1;
  endtask

  task automatic test_reset_mid_access;
    do_reset();
    bus_write(0, 8'h10, 8'h42);
    out_ready = 0;
    bus_write(1, 8'h00, 8'h99);
    mem_io = 1;
    c_ro = 1;
    mem_clk = 1;
    tick();
    mem_clk = 0;
    c_ro = 0;
    reset = 0;
    mem_io = 0;
    addr_bus = 8'h10;
    c_ri = 1;
    tb_bus = 8'hFF;
    tb_drv = 1;
    mem_clk = 1;
    tick();
    mem_clk = 0;
    c_ri = 0;
    tb_drv = 0;
    c_ro = 1;
    #1;
    checks++;
    if (!(bus === 8'hzz || bus === 8'h00)) begin
      failures++;
      $display("FAIL rst_bus_release got=%h want=zz", bus);
    end
    c_ro = 0;
    reset = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_fifo_empty got=%b want=0", out_valid);
    end
    checks++;
    if (out_overflow !== 1'b0 || in_underflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b%b want=00", out_overflow, in_underflow);
    end
    c_ro = 1;
    #1;
    checks++;
    if (bus !== 8'h42) begin
      failures++;
      $display("FAIL rst_ram_kept got=%h want=42", bus);
    end
    c_ro = 0;
    #1;
  endtask

  task automatic test_illegal;
    do_reset();
    bus_write(0, 8'h20, 8'h33);
    mem_io = 0;
    addr_bus = 8'h20;
    c_ri = 1;
    c_ro = 1;
    #1;
    checks++;
    if (!(bus === 8'hzz || bus === 8'h00)) begin
      failures++;
      $display("FAIL ill_bus_release got=%h want=zz", bus);
    end
    mem_clk = 1;
    tick();
    mem_io = 1;
    tick();
    mem_clk = 0;
    c_ri = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ill_no_push got=%b want=0", out_valid);
    end
    checks++;
    if (in_underflow !== 1'b0) begin
      failures++;
      $display("FAIL ill_no_underflow got=%b want=0", in_underflow);
    end
    mem_io = 0;
    #1;
    checks++;
    if (bus !== 8'h33) begin
      failures++;
      $display("FAIL ill_ram_kept got=%h want=33", bus);
    end
    c_ro = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 0;
    addr_bus = 0;
    c_ri = 0;
    c_ro = 0;
    mem_clk = 0;
    mem_io = 0;
    out_ready = 0;
    in_data = 0;
    in_valid = 0;
    tb_bus = 0;
    tb_drv = 0;
    test_reset();
    test_ram();
    test_out_fifo();
    test_full_push_pop();
    test_in_path();
    test_back_to_back();
    test_reset_mid_access();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
